// File: rtl/ddr_prbs_check_ctrl_if.sv
// Control, DDR sample and status bundle between the capture flops, the
// PRBS check sequencer and the status mux.
interface ddr_prbs_check_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             ena;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             rise_bit;
    logic             fall_bit;
    logic             capture_en;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output ena, start, len, rise_bit, fall_bit,
        input  capture_en, busy, done, pass, err_cnt
    );

    modport slave (
        input  ena, start, len, rise_bit, fall_bit,
        output capture_en, busy, done, pass, err_cnt
    );
endinterface

// File: rtl/ddr_prbs_check_ctrl.sv
// Sequences the DDR capture path: self-seeds a PRBS5 predictor from the
// received stream, then counts rise/fall bit errors over a programmed length.
module ddr_prbs_check_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ddr_prbs_check_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SEED, CHECK, DONE} state_e;

    state_e           state_q;
    logic [4:0]       s_q;
    logic [CNT_W-1:0] remain_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [1:0]       seed_cnt_q;
    logic             capture_en_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    logic [4:0]       seed_s_d;
    logic [4:0]       pred_s_d;
    logic             p1;
    logic             p2;
    logic             e1;
    logic             e2;
    logic [CNT_W:0]   err_sum;
    logic [CNT_W-1:0] err_cnt_d;

    // s[0] is the newest bit; each cycle shifts in the earlier (rise) then the later (fall) bit.
    always_comb begin
        seed_s_d  = {s_q[2:0], bus.rise_bit, bus.fall_bit};
        p1        = ~(s_q[4] ^ s_q[2]);
        p2        = ~(s_q[3] ^ s_q[1]);
        pred_s_d  = {s_q[2:0], p1, p2};
        e1        = bus.rise_bit ^ p1;
        e2        = bus.fall_bit ^ p2;
        err_sum   = {1'b0, err_cnt_q} + {{CNT_W{1'b0}}, e1} + {{CNT_W{1'b0}}, e2};
        err_cnt_d = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            s_q          <= '0;
            remain_q     <= '0;
            err_cnt_q    <= '0;
            seed_cnt_q   <= '0;
            capture_en_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else if (bus.ena) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q      <= SEED;
                        remain_q     <= bus.len;
                        err_cnt_q    <= '0;
                        pass_q       <= 1'b0;
                        seed_cnt_q   <= '0;
                        capture_en_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                SEED: begin
                    s_q        <= seed_s_d;
                    seed_cnt_q <= seed_cnt_q + 2'd1;
                    // Three pairs fill the 5-bit history; an all-ones seed would lock the predictor.
                    if (seed_cnt_q == 2'd2) begin
                        if (seed_s_d == 5'b11111) begin
                            seed_cnt_q <= '0;
                        end else begin
                            state_q <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    s_q       <= pred_s_d;
                    err_cnt_q <= err_cnt_d;
                    remain_q  <= remain_q - CNT_W'(1);
                    if (remain_q == CNT_W'(1)) begin
                        state_q      <= DONE;
                        done_q       <= 1'b1;
                        capture_en_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                end
                DONE: begin
                    pass_q  <= (err_cnt_q == '0);
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.capture_en = capture_en_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_ddr_prbs_check_ctrl.sv
// Randomized bench for ddr_prbs_check_ctrl against a bit-stream model of the
// seed search, free-running PRBS5 prediction and saturating error count.
module tb_ddr_prbs_check_ctrl;
    localparam int CNT_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;
    localparam int DEPTH = 512;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ddr_prbs_check_ctrl_if #(.CNT_W(CNT_W)) bus ();
    ddr_prbs_check_ctrl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit r_s [DEPTH];
    bit f_s [DEPTH];
    int cum_err [DEPTH];
    int seed_end;
    int total_err;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Stream entry k is the pair presented at edge E0+k. Modes: 0 PRBS from 00000,
    // 1 PRBS from a random phase, 2 all zeros, 3 random, 4 ones then PRBS, 5 PRBS (inverted later).
    task automatic gen(input int mode, input int ones_pre);
        bit g[$];
        bit b;
        int st;
        st = (mode == 1) ? int'($urandom_range(0, 30)) : 0;
        for (int i = 4; i >= 0; i--) g.push_back(st[i]);
        r_s[0] = 1'b0;
        f_s[0] = 1'b0;
        for (int k = 1; k < DEPTH; k++) begin
            for (int j = 0; j < 2; j++) begin
                if (mode == 2) b = 1'b0;
                else if (mode == 3) b = 1'($urandom_range(0, 1));
                else if (mode == 4 && k <= ones_pre) b = 1'b1;
                else begin
                    b = ~(g[g.size()-5] ^ g[g.size()-3]);
                    g.push_back(b);
                end
                if (j == 0) r_s[k] = b;
                else        f_s[k] = b;
            end
        end
    endtask

    // Seeding looks at groups of three pairs; the predictor extends the 5 seed bits
    // with the PRBS5 rule and never looks at received data again.
    task automatic model(input int L);
        bit h[$];
        bit p;
        int e;
        seed_end = 0;
        do seed_end += 3;
        while (seed_end < 240 && (f_s[seed_end-2] & r_s[seed_end-1] & f_s[seed_end-1]
                                  & r_s[seed_end] & f_s[seed_end]) == 1'b1);
        h = {f_s[seed_end-2], r_s[seed_end-1], f_s[seed_end-1], r_s[seed_end], f_s[seed_end]};
        e = 0;
        for (int k = 0; k < DEPTH; k++) cum_err[k] = 0;
        for (int k = seed_end + 1; k <= seed_end + L; k++) begin
            p = ~(h[h.size()-5] ^ h[h.size()-3]);
            h.push_back(p);
            if (p != r_s[k]) e++;
            p = ~(h[h.size()-5] ^ h[h.size()-3]);
            h.push_back(p);
            if (p != f_s[k]) e++;
            if (e > MAXC) e = MAXC;
            cum_err[k] = e;
        end
        total_err = e;
    endtask

    task automatic abort_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_capture_en", int'(bus.capture_en), 0);
        chk("rst_busy",       int'(bus.busy), 0);
        chk("rst_done",       int'(bus.done), 0);
        chk("rst_pass",       int'(bus.pass), 0);
        chk("rst_err_cnt",    int'(bus.err_cnt), 0);
        bus.start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_hold_done", int'(bus.done), 0);
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("post_rst_done", int'(bus.done), 0);
            chk("post_rst_busy", int'(bus.busy), 0);
        end
    endtask

    // Offsets flip_at/pulse_at/freeze_at/rst_at are in CHECK cycles after the seed (0 = unused).
    task automatic run(input int mode, input int len_field, input int flip_at, input int pulse_at,
                       input int freeze_at, input int rst_at, input bit hold);
        int  L, k, wall, frz_left, last;
        bit  frz_used, en;
        L = (len_field == 0) ? MAXC + 1 : len_field;
        gen(mode, 5);
        model(L);
        if (mode == 5) begin
            for (int i = seed_end + 1; i < DEPTH; i++) begin
                r_s[i] = ~r_s[i];
                f_s[i] = ~f_s[i];
            end
            model(L);
        end
        if (flip_at > 0) begin
            f_s[seed_end + flip_at] = ~f_s[seed_end + flip_at];
            model(L);
        end
        last = seed_end + L;
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = CNT_W'(len_field);
        bus.ena   = 1'b1;
        k = -1; wall = 0; frz_left = 0; frz_used = 1'b0;
        while (k < last + 1 && wall < 2000) begin
            en = bus.ena;
            @(posedge clk);
            wall++;
            if (en) k++;
            @(negedge clk);
            if (k == last + 1) begin
                chk("end_busy",    int'(bus.busy), 0);
                chk("end_done",    int'(bus.done), 0);
                chk("end_err_cnt", int'(bus.err_cnt), total_err);
                chk("end_pass",    int'(bus.pass), (total_err == 0) ? 1 : 0);
            end else if (k == last) begin
                chk("done_pulse",   int'(bus.done), 1);
                chk("done_busy",    int'(bus.busy), 0);
                chk("done_capture", int'(bus.capture_en), 0);
                chk("done_err_cnt", int'(bus.err_cnt), total_err);
                chk("done_pass",    int'(bus.pass), 0);
                if (!en) chk("done_frozen", int'(bus.done), 1);
                else     chk("done_cycle", wall, last + 1 + (frz_used ? 3 : 0));
            end else begin
                chk("run_busy",    int'(bus.busy), 1);
                chk("run_capture", int'(bus.capture_en), 1);
                chk("run_done",    int'(bus.done), 0);
                chk("run_err_cnt", int'(bus.err_cnt), cum_err[k]);
                chk("run_pass",    int'(bus.pass), 0);
            end
            if (rst_at > 0 && k == seed_end + rst_at) begin
                abort_reset();
                return;
            end
            bus.start = hold || (pulse_at > 0 && k == seed_end + pulse_at);
            if (!frz_used && freeze_at > 0 && k == seed_end + freeze_at) begin
                frz_used = 1'b1;
                frz_left = 3;
            end
            bus.ena = (frz_left == 0);
            if (frz_left > 0) frz_left--;
            if (bus.ena) begin
                bus.rise_bit = r_s[k + 1];
                bus.fall_bit = f_s[k + 1];
            end else begin
                bus.rise_bit = 1'($urandom_range(0, 1));
                bus.fall_bit = 1'($urandom_range(0, 1));
            end
        end
        chk("run_edges", k, last + 1);
        if (hold) begin
            @(posedge clk);
            @(negedge clk);
            chk("retrigger_busy", int'(bus.busy), 1);
            abort_reset();
        end
    endtask

    initial begin
        bus.ena      = 1'b0;
        bus.start    = 1'b0;
        bus.len      = '0;
        bus.rise_bit = 1'b0;
        bus.fall_bit = 1'b0;
        #1;
        chk("reset_capture_en", int'(bus.capture_en), 0);
        chk("reset_busy",       int'(bus.busy), 0);
        chk("reset_done",       int'(bus.done), 0);
        chk("reset_pass",       int'(bus.pass), 0);
        chk("reset_err_cnt",    int'(bus.err_cnt), 0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        @(negedge clk);
        bus.ena = 1'b1;

        run(0, 8, 0, 0, 0, 0, 1'b0);   // clean stream
        run(0, 8, 4, 0, 0, 0, 1'b0);   // single fall_bit flip in 4th CHECK cycle
        run(2, 0, 0, 0, 0, 0, 1'b0);   // constant zero, len=0 -> 256 cycles
        run(5, 0, 0, 0, 0, 0, 1'b0);   // every checked bit wrong: saturation
        run(4, 8, 0, 0, 0, 0, 1'b0);   // all-ones lockup then PRBS
        run(1, 20, 0, 5, 7, 0, 1'b0);  // start pulse and 3-cycle freeze mid-CHECK
        run(0, 12, 0, 0, 0, 4, 1'b0);  // async reset mid-CHECK
        run(0, 6, 0, 0, 0, 0, 1'b0);   // normal run after reset
        run(1, 1, 0, 0, 0, 0, 1'b0);   // shortest run
        run(1, 10, 0, 0, 0, 0, 1'b1);  // start held high re-triggers
        for (int i = 0; i < 8; i++) begin
            int md, ln, fl;
            md = (i % 2 == 0) ? 1 : 3;
            ln = int'($urandom_range(1, 40));
            fl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, ln)) : 0;
            run(md, ln, fl, 0, 0, 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
